// File: rtl/onehot_enc.sv
// Lowest-set-bit encoder: returns the index of the least significant set bit
// of vec_i plus a flag that says whether any bit is set.
module onehot_enc #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      idx_o = '0;
      any_o = |vec_i;
      // Walk downward so the lowest set bit is the last assignment and wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/arbiter_lock.sv
// Request front end and single-entry output stage for an external fixed-priority
// arbiter; ownership is locked to the granted source until its last beat.
module arbiter_lock #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic [N-1:0]   arb_req,
   input  logic [N-1:0]   arb_grant,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   output logic [IW-1:0]  out_owner,
   input  logic           out_ready,
   output logic           locked
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic            out_valid_q;
   logic [W-1:0]    out_data_q;
   logic            out_last_q;
   logic [IW-1:0]   out_owner_q;

   logic [W-1:0]    data_arr [N];
   logic [N-1:0]    eff;
   logic [IW-1:0]   sel_idx;
   logic            eff_any;
   logic            load_ok;
   logic            accept;
   logic [IW-1:0]   acc_idx;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign data_arr[gi] = in_data[gi*W +: W];
      end
   endgenerate

   // Grants on sources that are not valid are discarded before selection.
   assign eff     = arb_grant & in_valid;
   assign load_ok = !out_valid_q || out_ready;

   onehot_enc #(.N(N), .IW(IW)) u_sel (
      .vec_i (eff),
      .idx_o (sel_idx),
      .any_o (eff_any)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      arb_req  = '0;
      in_ready = '0;
      accept   = 1'b0;
      acc_idx  = sel_idx;
      case (state_q)
         IDLE: begin
            arb_req = in_valid;
            if (eff_any && load_ok) begin
               accept            = 1'b1;
               in_ready[sel_idx] = 1'b1;
               if (!in_last[sel_idx]) begin
                  state_d = LOCKED;
                  owner_d = sel_idx;
               end
            end
         end
         LOCKED: begin
            acc_idx = owner_q;
            if (in_valid[owner_q] && load_ok) begin
               accept            = 1'b1;
               in_ready[owner_q] = 1'b1;
               if (in_last[owner_q]) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_arr[acc_idx];
            out_last_q  <= in_last[acc_idx];
            out_owner_q <= acc_idx;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_owner = out_owner_q;
   assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_arbiter_lock.sv
// Directed bench for arbiter_lock with a behavioural fixed-priority arbiter
// whose grant can be overridden to inject malformed grants.
module tb_arbiter_lock;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic [N-1:0]   arb_req;
   logic [N-1:0]   arb_grant;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [IW-1:0]  out_owner;
   logic           out_ready;
   logic           locked;

   logic           force_en;
   logic [N-1:0]   force_val;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   // Fixed-priority arbiter: lowest requesting index wins.
   assign arb_grant = force_en ? force_val : (arb_req & (~arb_req + 1'b1));

   arbiter_lock #(.N(N), .W(W), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .arb_req   (arb_req),
      .arb_grant (arb_grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_owner (out_owner),
      .out_ready (out_ready),
      .locked    (locked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int k, input logic [W-1:0] v);
      in_data[k*W +: W] = v;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b1;
      force_en  = 1'b0;
      force_val = '0;

      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_last",  32'(out_last),  32'h0);
      chk("rst_out_owner", 32'(out_owner), 32'h0);
      chk("rst_locked",    32'(locked),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Two single-beat sources; priority order 1 then 3.
      in_valid = 4'b1010;
      in_last  = 4'b1111;
      set_data(1, 8'h11);
      set_data(3, 8'h33);
      #1;
      chk("t1_arb_req",  32'(arb_req),  32'hA);
      chk("t1_in_ready", 32'(in_ready), 32'h2);
      tick();
      chk("t1_data_a",  32'(out_data),  32'h11);
      chk("t1_owner_a", 32'(out_owner), 32'h1);
      chk("t1_valid_a", 32'(out_valid), 32'h1);
      in_valid = 4'b1000;
      #1;
      chk("t1_in_ready_b", 32'(in_ready), 32'h8);
      tick();
      chk("t1_data_b",  32'(out_data),  32'h33);
      chk("t1_owner_b", 32'(out_owner), 32'h3);
      in_valid = '0;
      tick();
      chk("t1_drain_valid", 32'(out_valid), 32'h0);
      chk("t1_hold_data",   32'(out_data),  32'h33);

      // Three-beat packet from src2 with src0 contending from beat 2.
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      set_data(2, 8'hA0);
      #1;
      chk("t2_b1_ready", 32'(in_ready), 32'h4);
      tick();
      chk("t2_b1_data",   32'(out_data), 32'hA0);
      chk("t2_b1_locked", 32'(locked),   32'h1);
      chk("t2_b1_last",   32'(out_last), 32'h0);
      in_valid = 4'b0101;
      in_last  = 4'b0001;
      set_data(0, 8'h0F);
      set_data(2, 8'hA1);
      #1;
      chk("t2_b2_arb_req", 32'(arb_req),  32'h0);
      chk("t2_b2_ready",   32'(in_ready), 32'h4);
      tick();
      chk("t2_b2_data",   32'(out_data), 32'hA1);
      chk("t2_b2_locked", 32'(locked),   32'h1);
      in_last = 4'b0101;
      set_data(2, 8'hA2);
      #1;
      chk("t2_b3_arb_req", 32'(arb_req),  32'h0);
      chk("t2_b3_ready",   32'(in_ready), 32'h4);
      tick();
      chk("t2_b3_data",   32'(out_data), 32'hA2);
      chk("t2_b3_last",   32'(out_last), 32'h1);
      chk("t2_b3_locked", 32'(locked),   32'h0);
      in_valid = 4'b0001;
      #1;
      chk("t2_src0_req",   32'(arb_req),  32'h1);
      chk("t2_src0_ready", 32'(in_ready), 32'h1);
      tick();
      chk("t2_src0_data",  32'(out_data),  32'h0F);
      chk("t2_src0_owner", 32'(out_owner), 32'h0);

      // Backpressure: hold 0x5C for three cycles, then accept pending 0x66.
      in_valid = 4'b0010;
      in_last  = 4'b1111;
      set_data(1, 8'h5C);
      tick();
      chk("t3_load_data", 32'(out_data), 32'h5C);
      out_ready = 1'b0;
      set_data(1, 8'h66);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t3_stall_ready_%0d", i), 32'(in_ready), 32'h0);
         tick();
         chk($sformatf("t3_stall_data_%0d", i),  32'(out_data),  32'h5C);
         chk($sformatf("t3_stall_valid_%0d", i), 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_release_ready", 32'(in_ready), 32'h2);
      tick();
      chk("t3_release_data", 32'(out_data), 32'h66);
      in_valid = '0;

      // Full throughput: 8-beat packet from src1, one beat per cycle.
      for (int i = 0; i < 8; i++) begin
         in_valid = 4'b0010;
         in_last  = (i == 7) ? 4'b0010 : 4'b0000;
         set_data(1, 8'(8'h80 + i));
         tick();
         chk($sformatf("t4_valid_%0d", i), 32'(out_valid), 32'h1);
         chk($sformatf("t4_data_%0d", i),  32'(out_data),  32'(8'h80 + i));
      end
      in_valid = '0;
      chk("t4_unlocked", 32'(locked), 32'h0);
      tick();

      // Asynchronous reset while locked with output valid.
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      set_data(2, 8'hB0);
      tick();
      chk("t5_pre_locked", 32'(locked),    32'h1);
      chk("t5_pre_valid",  32'(out_valid), 32'h1);
      in_valid = 4'b1010;
      in_last  = 4'b1111;
      set_data(1, 8'h21);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_valid",  32'(out_valid), 32'h0);
      chk("t5_rst_locked", 32'(locked),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_after_ready", 32'(in_ready), 32'h2);
      tick();
      chk("t5_after_owner", 32'(out_owner), 32'h1);
      chk("t5_after_data",  32'(out_data),  32'h21);
      in_valid = '0;
      tick();

      // Malformed grants.
      force_en  = 1'b1;
      force_val = 4'b0110;
      in_valid  = 4'b0100;
      set_data(2, 8'hC2);
      #1;
      chk("t6_ready_single", 32'(in_ready), 32'h4);
      tick();
      chk("t6_data",  32'(out_data),  32'hC2);
      chk("t6_owner", 32'(out_owner), 32'h2);
      in_valid = 4'b0110;
      #1;
      chk("t6_ready_multi", 32'(in_ready), 32'h2);
      force_val = 4'b0001;
      in_valid  = 4'b0100;
      #1;
      chk("t6_ready_nonvalid", 32'(in_ready), 32'h0);
      in_valid = '0;
      force_en = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/arbiter_lock.md
Name: arbiter_lock

Overview:
- Request-side front end and data path for the codebase's combinational fixed-priority arbiter (request[0] highest priority).
- Collects N valid/ready sources and drives the arbiter's request vector.
- Takes the arbiter's one-hot grant, registers the winning source's beat into a single-entry output stage, and locks ownership until that source's last beat.
- Sits between N producers and one shared consumer.

Parameters:
N, 4, number of requesters (N >= 2)
W, 8, data width per requester
IW, $clog2(N), owner index width

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  N  per-source beat valid
in_data  input  N*W  per-source data; source k is in_data[k*W +: W]
in_last  input  N  per-source last beat of packet
in_ready  output  N  per-source accept; at most one bit high
arb_req  output  N  request vector to arbiter
arb_grant  input  N  one-hot grant from arbiter, same cycle
out_valid  output  1  registered output valid
out_data  output  W  registered output data
out_last  output  1  registered last flag
out_owner  output  IW  index of source that produced out_data
out_ready  input  1  downstream accept
locked  output  1  high while a multi-beat packet owns the path

Behaviour:
- Reset, asynchronous, any time:
  - out_valid=0, out_data=0, out_last=0, out_owner=0, locked=0, state=IDLE.
  - A packet in flight is dropped; no partial resume.
- load_ok = !out_valid || out_ready. The register accepts a new beat in the same cycle the old one drains, giving full throughput.
- States: IDLE, LOCKED (locked = state==LOCKED).
- IDLE:
  - arb_req = in_valid.
  - eff = arb_grant & in_valid. If more than one bit is set, the lowest set bit wins; a grant on a non-valid source is ignored.
  - If eff != 0 and load_ok: in_ready[sel]=1 combinationally. Next edge loads out_data, out_last and out_owner=sel, and sets out_valid=1.
  - If the accepted beat has in_last=0: go to LOCKED and store owner=sel.
  - If eff == 0 or !load_ok: in_ready=0 and the state is held.
- LOCKED:
  - arb_req = 0; the arbiter is bypassed.
  - Only the owner is serviced: in_ready[owner] = in_valid[owner] && load_ok.
  - Each accepted beat loads the output register.
  - Accepting a beat with in_last=1 returns to IDLE on the next edge.
  - Other sources stay stalled: in_ready=0 for them, regardless of their valid.
- If out_ready=0 and the source deasserts in_valid, the output keeps its data. out_valid, out_data, out_last and out_owner stay stable while out_valid && !out_ready.
- When out_valid && out_ready and no new beat loads: out_valid falls next cycle; data is don't-care but held.
- Single-beat packet (in_last=1 on the first beat): no LOCKED visit.
- Latency: source beat accepted at edge t appears at out_* after edge t, visible in cycle t+1.
- No combinational path from out_ready to arb_req.
- Paths from out_ready to in_ready, and from arb_grant to in_ready, are combinational.

Decomposition:
- No shared package needed.
- State encoding is a local 1-bit enum (IDLE=0, LOCKED=1).
- One sub-module, onehot_enc: N-bit lowest-set-bit select to IW-bit index plus any-bit flag. Reused for the eff select.
- The arbiter itself stays external and is connected by the integrating level.

Test Plan:
- Arbiter connected, N=4, W=8, out_ready=1. in_valid=4'b1010, data src1=0x11, src3=0x33, in_last all 1 → cycle 1: out_data=0x11, out_owner=1; cycle 2: out_data=0x33, out_owner=3.
- Src2 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (last on 0xA2) while src0 holds valid from beat 2 onward:
  - locked=1 after beat 1, arb_req=0 while locked, in_ready[0]=0 throughout.
  - Src0 is granted in the cycle after 0xA2 is accepted.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data 0x5C → out_data stays 0x5C and all in_ready=0. When out_ready rises, the pending source is accepted in that same cycle.
- Full throughput: src1 streams 8 beats with out_ready=1 → 8 consecutive cycles of out_valid=1, no bubbles.
- Reset asserted mid-packet (LOCKED, out_valid=1) → immediately out_valid=0, locked=0. After release, the highest-priority valid source wins.
- Malformed grant (force arb_grant=4'b0110, in_valid=4'b0100) → src2 accepted, in_ready=4'b0100.
